// File: rtl/avst_demultiplexer.sv
// Avalon-ST packet demux: steers whole packets to output one/two by a channel bit sampled at sop.
// Latency: 1 cycle (one register slot per output); full throughput when the routed sink is ready.
// Backpressure: input stalls while the routed slot is busy (head-of-line); dropped beats always accepted.
//
// Ports:
//   clk, reset_n           - rising-edge clock, async active-low reset
//   avsi_*                 - input stream (channel/data/valid/sop/eop/empty, ready out)
//   avso_one_*, avso_two_* - output streams, one register slot each
//   err_count              - saturating count of framing errors
module avst_demultiplexer #(
  parameter int data_width    = 128,
  parameter int empty_width   = 4,
  parameter int channel_width = 10,
  parameter int route_bit     = 0,
  parameter int cnt_width     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [channel_width-1:0] avsi_channel,
  input  logic [data_width-1:0]    avsi_data,
  input  logic                     avsi_valid,
  input  logic                     avsi_sop,
  input  logic                     avsi_eop,
  input  logic [empty_width-1:0]   avsi_empty,
  output logic                     avsi_ready,
  output logic [channel_width-1:0] avso_one_channel,
  output logic [data_width-1:0]    avso_one_data,
  output logic                     avso_one_sop,
  output logic                     avso_one_eop,
  output logic [empty_width-1:0]   avso_one_empty,
  output logic                     avso_one_valid,
  input  logic                     avso_one_ready,
  output logic [channel_width-1:0] avso_two_channel,
  output logic [data_width-1:0]    avso_two_data,
  output logic                     avso_two_sop,
  output logic                     avso_two_eop,
  output logic [empty_width-1:0]   avso_two_empty,
  output logic                     avso_two_valid,
  input  logic                     avso_two_ready,
  output logic [cnt_width-1:0]     err_count
);

  typedef enum logic {ST_IDLE = 1'b0, ST_PKT = 1'b1} state_t;

  localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_route_q;
  logic [cnt_width-1:0]     r_err;

  logic                     r_one_valid, r_two_valid;
  logic [channel_width-1:0] r_one_channel, r_two_channel;
  logic [data_width-1:0]    r_one_data, r_two_data;
  logic                     r_one_sop, r_two_sop;
  logic                     r_one_eop, r_two_eop;
  logic [empty_width-1:0]   r_one_empty, r_two_empty;

  logic w_route_now;   // 0 -> output one, 1 -> output two
  logic w_drop;        // beat outside a packet: swallowed and counted
  logic w_sop_in_pkt;  // restart inside an open packet: forwarded and counted
  logic w_free_one, w_free_two;
  logic w_accept, w_fwd, w_err_evt;
  logic w_load_one, w_load_two;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: every forwarded beat moves to PKT unless it closes the packet
  always_comb begin
    w_state_nxt = r_state;
    if (w_fwd) begin
      w_state_nxt = avsi_eop ? ST_IDLE : ST_PKT;
    end
  end

  // Output/decode logic. avsi_ready never looks at avsi_valid.
  always_comb begin
    w_drop       = (r_state == ST_IDLE) && !avsi_sop;
    w_sop_in_pkt = (r_state == ST_PKT) && avsi_sop;
    // A new route is only taken from a sop beat (or any IDLE beat, which is
    // either a sop or dropped anyway); mid-packet channel bits are ignored.
    w_route_now  = ((r_state == ST_IDLE) || avsi_sop) ? avsi_channel[route_bit] : r_route_q;
    w_free_one   = !r_one_valid || avso_one_ready;
    w_free_two   = !r_two_valid || avso_two_ready;
    avsi_ready   = w_drop ? 1'b1 : (w_route_now ? w_free_two : w_free_one);
    w_accept     = avsi_valid && avsi_ready;
    w_fwd        = w_accept && !w_drop;
    w_err_evt    = w_accept && (w_drop || w_sop_in_pkt);
    w_load_one   = w_fwd && !w_route_now;
    w_load_two   = w_fwd && w_route_now;
  end

  // Route latch and saturating error counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_route_q <= 1'b0;
      r_err     <= '0;
    end else begin
      if (w_accept && avsi_sop) begin
        r_route_q <= w_route_now;
      end
      if (w_err_evt && (r_err != '1)) begin
        r_err <= r_err + CNT_ONE;
      end
    end
  end

  // Output slot one: reload wins over drain so back-to-back beats have no bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_one_valid   <= 1'b0;
      r_one_channel <= '0;
      r_one_data    <= '0;
      r_one_sop     <= 1'b0;
      r_one_eop     <= 1'b0;
      r_one_empty   <= '0;
    end else if (w_load_one) begin
      r_one_valid   <= 1'b1;
      r_one_channel <= avsi_channel;
      r_one_data    <= avsi_data;
      r_one_sop     <= avsi_sop;
      r_one_eop     <= avsi_eop;
      r_one_empty   <= avsi_empty;
    end else if (avso_one_ready) begin
      r_one_valid   <= 1'b0;
    end
  end

  // Output slot two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_two_valid   <= 1'b0;
      r_two_channel <= '0;
      r_two_data    <= '0;
      r_two_sop     <= 1'b0;
      r_two_eop     <= 1'b0;
      r_two_empty   <= '0;
    end else if (w_load_two) begin
      r_two_valid   <= 1'b1;
      r_two_channel <= avsi_channel;
      r_two_data    <= avsi_data;
      r_two_sop     <= avsi_sop;
      r_two_eop     <= avsi_eop;
      r_two_empty   <= avsi_empty;
    end else if (avso_two_ready) begin
      r_two_valid   <= 1'b0;
    end
  end

  assign avso_one_valid   = r_one_valid;
  assign avso_one_channel = r_one_channel;
  assign avso_one_data    = r_one_data;
  assign avso_one_sop     = r_one_sop;
  assign avso_one_eop     = r_one_eop;
  assign avso_one_empty   = r_one_empty;
  assign avso_two_valid   = r_two_valid;
  assign avso_two_channel = r_two_channel;
  assign avso_two_data    = r_two_data;
  assign avso_two_sop     = r_two_sop;
  assign avso_two_eop     = r_two_eop;
  assign avso_two_empty   = r_two_empty;
  assign err_count        = r_err;

endmodule

// File: tb/tb_avst_demultiplexer.sv
module tb_avst_demultiplexer;

  localparam int DW = 128;
  localparam int EW = 4;
  localparam int CW = 10;
  localparam int NW = 3;  // narrow counter so saturation is reachable

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [EW-1:0] emp;
  } beat_t;

  typedef struct {
    beat_t b;
    int    acc;
    bit    lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CW-1:0] avsi_channel = '0;
  logic [DW-1:0] avsi_data = '0;
  logic          avsi_valid = 1'b0;
  logic          avsi_sop = 1'b0;
  logic          avsi_eop = 1'b0;
  logic [EW-1:0] avsi_empty = '0;
  logic          avsi_ready;
  logic [CW-1:0] avso_one_channel, avso_two_channel;
  logic [DW-1:0] avso_one_data, avso_two_data;
  logic          avso_one_sop, avso_two_sop, avso_one_eop, avso_two_eop;
  logic [EW-1:0] avso_one_empty, avso_two_empty;
  logic          avso_one_valid, avso_two_valid;
  logic          avso_one_ready = 1'b1;
  logic          avso_two_ready = 1'b1;
  logic [NW-1:0] err_count;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  exp_t q_one[$];
  exp_t q_two[$];

  avst_demultiplexer #(
    .data_width(DW), .empty_width(EW), .channel_width(CW), .route_bit(0), .cnt_width(NW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .avsi_channel(avsi_channel), .avsi_data(avsi_data), .avsi_valid(avsi_valid),
    .avsi_sop(avsi_sop), .avsi_eop(avsi_eop), .avsi_empty(avsi_empty), .avsi_ready(avsi_ready),
    .avso_one_channel(avso_one_channel), .avso_one_data(avso_one_data), .avso_one_sop(avso_one_sop),
    .avso_one_eop(avso_one_eop), .avso_one_empty(avso_one_empty), .avso_one_valid(avso_one_valid),
    .avso_one_ready(avso_one_ready),
    .avso_two_channel(avso_two_channel), .avso_two_data(avso_two_data), .avso_two_sop(avso_two_sop),
    .avso_two_eop(avso_two_eop), .avso_two_empty(avso_two_empty), .avso_two_valid(avso_two_valid),
    .avso_two_ready(avso_two_ready),
    .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] n);
    return {4{n}};
  endfunction

  // Drive one beat and wait for acceptance. dest: 0 = dropped, 1 = output one, 2 = output two.
  task automatic send(input logic [CW-1:0] ch, input logic [31:0] tag, input logic sop,
                      input logic eop, input logic [EW-1:0] emp, input int dest);
    exp_t e;
    bit   done;
    done = 0;
    e.b = '{ch: ch, d: mk(tag), sop: sop, eop: eop, emp: emp};
    avsi_channel = ch; avsi_data = mk(tag); avsi_sop = sop; avsi_eop = eop;
    avsi_empty = emp; avsi_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (avsi_ready) begin
        e.acc = cyc;
        if (dest == 1) begin e.lat = avso_one_ready; q_one.push_back(e); end
        if (dest == 2) begin e.lat = avso_two_ready; q_two.push_back(e); end
        done = 1;
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL send_timeout: beat tag %0h never accepted", tag);
    end
    avsi_valid = 1'b0;
  endtask

  task automatic mon(input int port, input beat_t act);
    exp_t e;
    if (port == 1 && q_one.size() == 0) begin
      n_chk++; $display("FAIL one_unexpected: beat %0h with nothing expected", act); return;
    end
    if (port == 2 && q_two.size() == 0) begin
      n_chk++; $display("FAIL two_unexpected: beat %0h with nothing expected", act); return;
    end
    e = (port == 1) ? q_one.pop_front() : q_two.pop_front();
    check(port == 1 ? "one_payload" : "two_payload", 160'(act), 160'(e.b));
    if (e.lat) check(port == 1 ? "one_latency" : "two_latency", 160'(cyc), 160'(e.acc + 1));
  endtask

  // Monitor: consume every transfer on either output against its queue
  always @(negedge clk) begin
    if (reset_n) begin
      if (avso_one_valid && avso_one_ready)
        mon(1, {avso_one_channel, avso_one_data, avso_one_sop, avso_one_eop, avso_one_empty});
      if (avso_two_valid && avso_two_ready)
        mon(2, {avso_two_channel, avso_two_data, avso_two_sop, avso_two_eop, avso_two_empty});
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_one_valid", 160'(avso_one_valid), 160'(0));
    check("rst_two_valid", 160'(avso_two_valid), 160'(0));
    check("rst_err", 160'(err_count), 160'(0));
    check("rst_one_data", 160'(avso_one_data), 160'(0));
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // 3-beat packet to output one, back-to-back
    send(10'h002, 32'h1001, 1, 0, 0, 1);
    send(10'h002, 32'h1002, 0, 0, 0, 1);
    send(10'h002, 32'h1003, 0, 1, 3, 1);

    // single-beat packet to output two, then a stray beat must be dropped (FSM stayed IDLE)
    send(10'h001, 32'h2001, 1, 1, 5, 2);
    send(10'h001, 32'h2FFF, 0, 0, 0, 0);
    check("err_after_drop", 160'(err_count), 160'(1));

    // stall on output two
    avso_two_ready = 1'b0;
    send(10'h001, 32'h3001, 1, 0, 0, 2);
    avsi_channel = 10'h001; avsi_data = mk(32'h3002); avsi_sop = 0; avsi_eop = 0; avsi_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_ready", 160'(avsi_ready), 160'(0));
      check("stall_hold", 160'({avso_two_valid, avso_two_data}), 160'({1'b1, mk(32'h3001)}));
      check("stall_one_idle", 160'(avso_one_valid), 160'(0));
    end
    @(posedge clk); #1;
    avso_two_ready = 1'b1;
    send(10'h001, 32'h3002, 0, 0, 0, 2);
    send(10'h001, 32'h3003, 0, 1, 7, 2);

    // mid-packet channel flip is ignored
    send(10'h000, 32'h4001, 1, 0, 0, 1);
    send(10'h001, 32'h4002, 0, 0, 0, 1);
    send(10'h001, 32'h4003, 0, 1, 1, 1);

    // sop inside a packet restarts and re-routes
    send(10'h000, 32'h5001, 1, 0, 0, 1);
    send(10'h001, 32'h5002, 1, 0, 0, 2);
    check("err_after_restart", 160'(err_count), 160'(2));
    send(10'h000, 32'h5003, 0, 1, 2, 2);

    // saturation of the error counter
    for (int i = 0; i < 8; i++) send(10'h000, 32'h6000 + i, 0, 0, 0, 0);
    check("err_saturated", 160'(err_count), 160'(7));

    // reset during beat 2 of a 4-beat packet
    send(10'h002, 32'h7001, 1, 0, 0, 1);
    avsi_channel = 10'h002; avsi_data = mk(32'h7002); avsi_sop = 0; avsi_eop = 0; avsi_valid = 1;
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("arst_one_valid", 160'(avso_one_valid), 160'(0));
    check("arst_two_valid", 160'(avso_two_valid), 160'(0));
    check("arst_err", 160'(err_count), 160'(0));
    avsi_valid = 1'b0;
    check("arst_pending_one", 160'(q_one.size()), 160'(0));
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    send(10'h003, 32'h8001, 1, 0, 0, 2);
    send(10'h002, 32'h8002, 0, 1, 4, 2);

    repeat (5) @(posedge clk);
    #1;
    check("final_q_one_empty", 160'(q_one.size()), 160'(0));
    check("final_q_two_empty", 160'(q_two.size()), 160'(0));
    check("final_err", 160'(err_count), 160'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
